// File: rtl/clk_gen_multi_if.sv
// Configuration write bus for clk_gen_multi: one-cycle strobe carrying channel, divisor and mode.
interface clk_gen_multi_if #(
    parameter int CH_W  = 2,
    parameter int WIDTH = 26
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;

    modport master (output cfg_we, cfg_ch, cfg_div, cfg_mode);
    modport slave  (input  cfg_we, cfg_ch, cfg_div, cfg_mode);
endinterface

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable tick / derived-clock generator with double-buffered divisor and mode.
// Optional global phase realign input `sync` is compiled in with CLKGEN_SYNC_EN.
module clk_gen_ch #(
    parameter int               WIDTH       = 26,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = '0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdiv_i,
    input  logic             wmode_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pend_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d, act_div_q, act_div_d, sh_div_q, sh_div_d;
    logic             act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;

    always_comb begin
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        act_mode_d = act_mode_q;
        sh_div_d   = sh_div_q;
        sh_mode_d  = sh_mode_q;
        pend_d     = pend_q;
        clk_d      = clk_q;
        tick_d     = tick_q;
        if (sync_i || !en_i) begin
            // Idle/realign: drain the old shadow first, a same-cycle write then re-arms it
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
            if (pend_q) begin
                act_div_d  = sh_div_q;
                act_mode_d = sh_mode_q;
                pend_d     = 1'b0;
            end
            if (wr_i) begin
                sh_div_d  = wdiv_i;
                sh_mode_d = wmode_i;
                pend_d    = 1'b1;
            end
        end else if (cnt_q >= act_div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = act_mode_q ? 1'b1 : ~clk_q;
            if (wr_i) begin
                act_div_d  = wdiv_i;
                act_mode_d = wmode_i;
                sh_div_d   = wdiv_i;
                sh_mode_d  = wmode_i;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                act_div_d  = sh_div_q;
                act_mode_d = sh_mode_q;
                pend_d     = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q + WIDTH'(1);
            tick_d = 1'b0;
            if (act_mode_q) clk_d = 1'b0;
            if (wr_i) begin
                sh_div_d  = wdiv_i;
                sh_mode_d = wmode_i;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q      <= '0;
            act_div_q  <= DEFAULT_DIV;
            act_mode_q <= 1'b0;
            sh_div_q   <= DEFAULT_DIV;
            sh_mode_q  <= 1'b0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            act_mode_q <= act_mode_d;
            sh_div_q   <= sh_div_d;
            sh_mode_q  <= sh_mode_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;
endmodule

module clk_gen_multi #(
    parameter int          CHANNELS    = 4,
    parameter int          WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 49_999_999,
    parameter int          CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    clk_gen_multi_if.slave      cfg,
    input  logic [CHANNELS-1:0] ch_en,
`ifdef CLKGEN_SYNC_EN
    input  logic                sync,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);
    logic sync_w;
`ifdef CLKGEN_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    // Out-of-range cfg_ch values match no channel and are dropped
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_gen_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (WIDTH'(DEFAULT_DIV))
        ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .en_i    (ch_en[i]),
            .sync_i  (sync_w),
            .wr_i    (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))),
            .wdiv_i  (cfg.cfg_div),
            .wmode_i (cfg.cfg_mode),
            .clk_o   (clk_out[i]),
            .tick_o  (tick[i]),
            .pend_o  (pending[i])
        );
    end
endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi: 3 channels, 8-bit counters, reset divisor 3.
module tb_clk_gen_multi;
    logic       clk_in = 1'b0;
    logic       reset;
    logic [2:0] ch_en, clk_out, tick, pending;
    logic       sync;
    int         k, n_tot, n_bad;
    logic [2:0] et, ec;

    clk_gen_multi_if #(.CH_W(2), .WIDTH(8)) cfg ();

    clk_gen_multi #(
        .CHANNELS    (3),
        .WIDTH       (8),
        .DEFAULT_DIV (3)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .cfg     (cfg.slave),
        .ch_en   (ch_en),
`ifdef CLKGEN_SYNC_EN
        .sync    (sync),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        k++;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] div, input logic mode);
        cfg.cfg_we   = 1'b1;
        cfg.cfg_ch   = ch;
        cfg.cfg_div  = div;
        cfg.cfg_mode = mode;
    endtask

    initial begin
        n_tot = 0; n_bad = 0; k = 0;
        reset = 1'b1; ch_en = 3'b111; sync = 1'b0;
        cfg.cfg_we = 1'b0; cfg.cfg_ch = '0; cfg.cfg_div = '0; cfg.cfg_mode = 1'b0;
        repeat (3) step();
        chk("rst_tick", tick, 0);
        chk("rst_clk", clk_out, 0);
        chk("rst_pend", pending, 0);
        reset = 1'b0;
        k = 0;

        // div 3 everywhere: tick every 4th edge, clk_out period 8
        for (int j = 0; j < 12; j++) begin
            step();
            chk("a_tick", tick, (k % 4 == 0) ? 7 : 0);
            chk("a_clk", clk_out, ((k / 4) % 2 == 1) ? 7 : 0);
        end

        // ch1 div 9 written mid-period; transfer at its terminal edge 16
        step();
        wr(2'd1, 8'd9, 1'b0);
        step();
        cfg.cfg_we = 1'b0;
        chk("b_pend14", pending, 3'b010);
        while (k < 36) begin
            step();
            chk("b_pend", pending, (k == 15) ? 3'b010 : 3'b000);
            et[0] = (k % 4 == 0);
            et[2] = (k % 4 == 0);
            et[1] = (k <= 16) ? (k % 4 == 0) : ((k - 16) % 10 == 0);
            chk("b_tick", tick, et);
            chk("b_clk1", clk_out[1], (k < 16) ? ((k / 4) % 2) : (((k - 16) / 10) % 2));
        end

        // ch0: pending div 5, then div 0 on its terminal edge 40 overrides
        wr(2'd0, 8'd5, 1'b0);
        step();
        cfg.cfg_we = 1'b0;
        chk("c_pend37", pending[0], 1);
        step();
        step();
        chk("c_pend39", pending[0], 1);
        wr(2'd0, 8'd0, 1'b0);
        step();
        cfg.cfg_we = 1'b0;
        chk("c_pend40", pending, 0);
        chk("c_tick40", tick[0], 1);
        chk("c_clk40", clk_out[0], 0);
        while (k < 47) begin
            step();
            chk("c_tick0", tick[0], 1);
            chk("c_clk0", clk_out[0], k % 2);
        end

        // ch2 pulse div 4, written on its terminal edge 48
        wr(2'd2, 8'd4, 1'b1);
        step();
        cfg.cfg_we = 1'b0;
        chk("d_pend48", pending, 0);
        chk("d_clk48", clk_out[2], 0);
        while (k < 63) begin
            step();
            chk("d_tick2", tick[2], ((k - 48) % 5 == 0));
            chk("d_clk2", clk_out[2], ((k - 48) % 5 == 0));
        end
        step();
        step();
        ch_en = 3'b011;
        while (k < 68) begin
            step();
            chk("d_dis_tick", tick[2], 0);
            chk("d_dis_clk", clk_out[2], 0);
        end
        ch_en = 3'b111;
        while (k < 78) begin
            step();
            chk("d_ren_tick", tick[2], ((k - 68) % 5 == 0));
            chk("d_ren_clk", clk_out[2], ((k - 68) % 5 == 0));
        end

        // out-of-range channel write must be ignored
        wr(2'd3, 8'd1, 1'b1);
        step();
        cfg.cfg_we = 1'b0;
        chk("e_pend79", pending, 0);
        step();
        chk("e_pend80", pending, 0);
        while (k < 83) step();
        chk("e_tick83", tick, 3'b101);
        while (k < 86) step();
        chk("e_tick86", tick, 3'b011);

`ifdef CLKGEN_SYNC_EN
        // realign: ch0 div0, ch1 div9, ch2 pulse div4 all restart at edge 90
        while (k < 89) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("f_tick90", tick, 0);
        chk("f_clk90", clk_out, 0);
        while (k < 100) begin
            step();
            et = {(k == 95 || k == 100), (k == 100), 1'b1};
            ec = {(k == 95 || k == 100), (k == 100), (k % 2 == 1)};
            chk("f_tick", tick, et);
            chk("f_clk", clk_out, ec);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/clk_gen_multi.md
# clk_gen_multi

Multi-channel programmable clock/tick generator: the parametrised successor to the single fixed divider. Each channel divides `clk_in` by a runtime-programmable divisor and produces two outputs:
- a one-cycle `tick` enable;
- a derived `clk_out` in either 50% toggle mode or single-pulse mode.

Divisor and mode changes are double-buffered and applied only at the channel's terminal count, so derived outputs never glitch or produce a runt period. The block sits at the top of the design and feeds timers, display refresh and debounce logic.

## Interface
Parameters:
- `CHANNELS`, 4, number of independent divider channels (1..16).
- `WIDTH`, 26, divisor/counter width in bits.
- `DEFAULT_DIV`, 49_999_999, divisor loaded into every channel at reset (must fit in `WIDTH`).
- `CH_W`, derived: `$clog2(CHANNELS)`, minimum 1.

Ports:
- `clk_in`  input  1  sole clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `cfg_we`  input  1  configuration write strobe, one cycle per write.
- `cfg_ch`  input  CH_W  target channel; values >= `CHANNELS` are ignored.
- `cfg_div`  input  WIDTH  new divisor.
- `cfg_mode`  input  1  new mode: 0 = toggle, 1 = pulse.
- `ch_en`  input  CHANNELS  per-channel run enable.
- `sync`  input  1  global phase realign; present only with `CLKGEN_SYNC_EN`.
- `clk_out`  output  CHANNELS  derived clock per channel.
- `tick`  output  CHANNELS  one-cycle pulse per channel at terminal count.
- `pending`  output  CHANNELS  shadow config is waiting for the terminal count.

## Operation
Per-channel state:
- `cnt` (`WIDTH` bits);
- active `act_div` and `act_mode`;
- shadow `sh_div` and `sh_mode`;
- `pend` flag.

Reset (sampled high):
- `cnt` = 0, `act_div` = `DEFAULT_DIV`, `act_mode` = 0, `pend` = 0.
- `clk_out` = 0, `tick` = 0, `pending` = 0 on every channel.

Enabled channel, each edge:
- If `cnt >= act_div`, this is the terminal edge:
  - `cnt` <= 0 and `tick` <= 1.
  - Toggle mode: `clk_out` inverts. Pulse mode: `clk_out` <= 1.
  - If `pend`, then `act_div`/`act_mode` <= `sh_div`/`sh_mode` and `pend` <= 0.
- Otherwise `cnt` increments and `tick` <= 0. In pulse mode `clk_out` <= 0.
- The comparison is `>=`, not `==`.

Config write (`cfg_we` high, `cfg_ch` valid):
- Writes `sh_div`/`sh_mode` and sets `pend`.
- A second write before the terminal edge overwrites the shadow; last write wins.
- A write coinciding with that channel's terminal edge: the written value transfers directly to active and `pend` stays 0. The write wins over the old shadow.

Disabled channel (`ch_en[i]` = 0):
- `cnt` <= 0, `clk_out` <= 0, `tick` <= 0.
- A pending shadow transfers on the next edge, which clears `pend`.

Other rules:
- Divisor 0 is legal: `tick` is high every cycle and the toggle output runs at `clk_in`/2.
- `cnt` never wraps; its maximum value is `act_div`.

Priority (high to low): `reset`, `sync` (if compiled), disable, config-on-terminal, terminal, count.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `tick` period is `act_div + 1` cycles. Toggle-mode `clk_out` period is `2*(act_div + 1)` cycles at 50% duty.
- After reset release or enable, the first `tick` rises on the (`act_div + 1`)th rising edge at which the channel is enabled.
- A new divisor affects the period starting after the next terminal edge. Every completed period uses exactly one divisor.
- `pending` rises the edge after the write and falls on the transfer edge.

## Configuration
Macro: `CLKGEN_SYNC_EN`.

Defined:
- The `sync` port exists.
- `sync` high on an edge clears `cnt`, `clk_out` and `tick` on all channels and applies any pending shadow.
- Enabled channels then restart phase-aligned; the next `tick` on each channel comes `act_div + 1` edges later.
- A `cfg_we` in the same cycle goes to the shadow and sets `pend`.

Undefined: the `sync` port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset, all enabled, `DEFAULT_DIV` overridden to 3 → every `tick` pulses once per 4 cycles; `clk_out` toggles with period 8. Before that, during reset: all outputs 0.
- Channel 1 at div 3 mid-period, write div 9 → `pending[1]` is high until the terminal edge; the current period completes at 4 cycles, then ticks come every 10. No short period on `clk_out`.
- Write div 0 to channel 0 on the same edge as its terminal, plus a prior pending div 5 → the active divisor becomes 0, `pending[0]` = 0, and `tick[0]` is continuously high.
- Pulse mode, div 4 → `clk_out` is high for exactly 1 cycle out of 5, coincident with `tick`. Deasserting `ch_en` mid-count → outputs 0; re-enable → first tick after 5 cycles.
- With `CLKGEN_SYNC_EN`, channels at div 3 and div 5 at arbitrary phases, pulse `sync` → both ticks fire 4 and 6 edges later respectively, with `clk_out` restarting from 0.
- `cfg_ch` = `CHANNELS` (out of range, `CHANNELS` < 2^`CH_W`) with `cfg_we` → no state changes; `pending` stays all 0.
